// File: rtl/adec_ws.sv
// adec_ws: address decoder with a programmable window table and per-window wait states.
// Each accepted bus cycle selects one chip select for ws+1 cycles.
// RDY is held low for the ws wait cycles. The last cycle is a single ACCESS cycle.
module adec_ws #(
    parameter int ADDR_W = 19,
    parameter int NWIN   = 6,
    parameter int WS_W   = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     rw,
    input  logic                     valid,
    input  logic                     cfg_we,
    input  logic [$clog2(NWIN)-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0]        cfg_base,
    input  logic [ADDR_W-1:0]        cfg_limit,
    input  logic [WS_W-1:0]          cfg_ws,
    input  logic                     cfg_en,
    output logic [NWIN-1:0]          cs_n,
    output logic                     we_n,
    output logic                     rdy,
    output logic                     miss,
    output logic                     overrun
);

    localparam int IDX_W = $clog2(NWIN);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t              state;
    logic [WS_W-1:0]     cnt;
    logic                rw_l;

    logic [ADDR_W-1:0]   tbl_base  [NWIN];
    logic [ADDR_W-1:0]   tbl_limit [NWIN];
    logic [WS_W-1:0]     tbl_ws    [NWIN];
    logic [NWIN-1:0]     tbl_en;

    logic                hit;
    logic [IDX_W-1:0]    win;
    logic [WS_W-1:0]     win_ws;
    logic [NWIN-1:0]     sel_n;
    logic                start_wait;

    // Window table; entry 0 comes out of reset as a full-range background window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NWIN; k++) begin
                tbl_base[k]  <= '0;
                tbl_limit[k] <= (k == 0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
                tbl_ws[k]    <= '0;
                tbl_en[k]    <= (k == 0);
            end
        end else if (cfg_we && (32'(cfg_idx) < NWIN)) begin
            tbl_base[cfg_idx]  <= cfg_base;
            tbl_limit[cfg_idx] <= cfg_limit;
            tbl_ws[cfg_idx]    <= cfg_ws;
            tbl_en[cfg_idx]    <= cfg_en;
        end
    end

    // Priority decode: later (higher-index) matches overwrite earlier ones.
    always_comb begin
        hit    = 1'b0;
        win    = '0;
        win_ws = '0;
        for (int k = 0; k < NWIN; k++) begin
            if (tbl_en[k] && (addr >= tbl_base[k]) && (addr <= tbl_limit[k])) begin
                hit    = 1'b1;
                win    = IDX_W'(k);
                win_ws = tbl_ws[k];
            end
        end
        sel_n      = hit ? ~(NWIN'(1) << win) : {NWIN{1'b1}};
        start_wait = hit && (win_ws != '0);
    end

    // Direction of the accepted access, needed when WAIT hands over to ACCESS.
    always_ff @(posedge clock) begin
        if ((state != S_WAIT) && valid) begin
            rw_l <= rw;
        end
    end

    // Bus-cycle FSM with registered chip selects, strobes and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            cs_n    <= {NWIN{1'b1}};
            we_n    <= 1'b1;
            rdy     <= 1'b1;
            miss    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCESS: begin
                    if (valid) begin
                        cs_n <= sel_n;
                        miss <= ~hit;
                        if (start_wait) begin
                            state <= S_WAIT;
                            cnt   <= win_ws;
                            rdy   <= 1'b0;
                            we_n  <= 1'b1;
                        end else begin
                            state <= S_ACCESS;
                            cnt   <= '0;
                            rdy   <= 1'b1;
                            we_n  <= rw;
                        end
                    end else begin
                        state <= S_IDLE;
                        cs_n  <= {NWIN{1'b1}};
                        we_n  <= 1'b1;
                        rdy   <= 1'b1;
                        miss  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A new request while stalled is dropped but remembered.
                    if (valid) begin
                        overrun <= 1'b1;
                    end
                    cnt <= cnt - WS_W'(1);
                    if (cnt == WS_W'(1)) begin
                        state <= S_ACCESS;
                        rdy   <= 1'b1;
                        we_n  <= rw_l;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= {NWIN{1'b1}};
                    we_n  <= 1'b1;
                    rdy   <= 1'b1;
                    miss  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adec_ws.sv
// tb_adec_ws: directed and randomized bench for adec_ws against a timeline model
// of each accepted bus cycle (start cycle, winner, wait states, direction).
module tb_adec_ws;

    localparam int ADDR_W = 19;
    localparam int NWIN   = 6;
    localparam int WS_W   = 3;
    localparam int IDX_W  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              valid;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_limit;
    logic [WS_W-1:0]   cfg_ws;
    logic              cfg_en;
    logic [NWIN-1:0]   cs_n;
    logic              we_n;
    logic              rdy;
    logic              miss;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [ADDR_W-1:0] m_base  [NWIN];
    logic [ADDR_W-1:0] m_limit [NWIN];
    int                m_ws    [NWIN];
    bit                m_en    [NWIN];
    int                cyc;
    int                s_cyc;
    int                s_n;
    int                s_w;
    bit                s_hit;
    bit                s_rw;
    bit                m_ovr;

    adec_ws #(.ADDR_W(ADDR_W), .NWIN(NWIN), .WS_W(WS_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .rw        (rw),
        .valid     (valid),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit),
        .cfg_ws    (cfg_ws),
        .cfg_en    (cfg_en),
        .cs_n      (cs_n),
        .we_n      (we_n),
        .rdy       (rdy),
        .miss      (miss),
        .overrun   (overrun)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < NWIN; k++) begin
            m_base[k]  = '0;
            m_limit[k] = (k == 0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
            m_ws[k]    = 0;
            m_en[k]    = (k == 0);
        end
        s_cyc = -100;
        s_n   = 0;
        s_w   = 0;
        s_hit = 0;
        s_rw  = 1;
        m_ovr = 0;
    endfunction

    // Highest-index enabled window containing the address wins.
    function automatic void decode(input logic [ADDR_W-1:0] a, output bit h, output int w, output int n);
        h = 0;
        w = 0;
        n = 0;
        for (int k = NWIN - 1; k >= 0; k--) begin
            if (m_en[k] && (m_base[k] <= a) && (a <= m_limit[k])) begin
                h = 1;
                w = k;
                n = m_ws[k];
                break;
            end
        end
    endfunction

    // The CPU is stalled during the ws cycles that follow an accepted valid.
    function automatic bit m_rdy(input int c);
        return !((c >= s_cyc + 1) && (c <= s_cyc + s_n));
    endfunction

    task automatic check_all();
        logic [NWIN-1:0] e_cs;
        bit act;
        act  = (cyc >= s_cyc + 1) && (cyc <= s_cyc + s_n + 1);
        e_cs = '1;
        if (act && s_hit) e_cs[s_w] = 1'b0;
        chk("cs_n", 32'(cs_n), 32'(e_cs));
        chk("rdy", 32'(rdy), 32'(m_rdy(cyc)));
        chk("we_n", 32'(we_n), 32'(!((cyc == s_cyc + s_n + 1) && !s_rw)));
        chk("miss", 32'(miss), 32'((cyc == s_cyc + 1) && !s_hit));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Present the currently driven inputs to one rising edge, then check outputs.
    task automatic step();
        bit h;
        int w;
        int n;
        if (valid) begin
            if (m_rdy(cyc)) begin
                decode(addr, h, w, n);
                s_cyc = cyc;
                s_hit = h;
                s_w   = w;
                s_n   = h ? n : 0;
                s_rw  = rw;
            end else begin
                m_ovr = 1;
            end
        end
        if (cfg_we && (cfg_idx < NWIN)) begin
            m_base[cfg_idx]  = cfg_base;
            m_limit[cfg_idx] = cfg_limit;
            m_ws[cfg_idx]    = cfg_ws;
            m_en[cfg_idx]    = cfg_en;
        end
        @(posedge clock);
        cyc++;
        #1;
        valid  = 1'b0;
        cfg_we = 1'b0;
        check_all();
    endtask

    task automatic cfg(input int idx, input int b, input int l, input int ws, input bit en);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_base  = ADDR_W'(b);
        cfg_limit = ADDR_W'(l);
        cfg_ws    = WS_W'(ws);
        cfg_en    = en;
        step();
    endtask

    task automatic drive(input int a, input bit r);
        addr  = ADDR_W'(a);
        rw    = r;
        valid = 1'b1;
    endtask

    task automatic finish_access();
        for (int i = 0; i < 12 && (cyc <= s_cyc + s_n + 1); i++) step();
    endtask

    initial begin
        addr = '0; rw = 1'b1; valid = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_base = '0; cfg_limit = '0; cfg_ws = '0; cfg_en = 1'b0;
        cyc = 0;
        m_reset();

        repeat (3) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Background window after reset
        drive(32'h01234, 1'b1); step();
        chk("bg_cs", 32'(cs_n), 32'h3E);
        chk("bg_rdy", 32'(rdy), 32'd1);
        chk("bg_we", 32'(we_n), 32'd1);
        step();
        chk("bg_end", 32'(cs_n), 32'h3F);

        // Three wait states on a write
        cfg(2, 32'hDC00, 32'hDC0F, 3, 1'b1);
        drive(32'hDC05, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ws3_cs", 32'(cs_n), 32'h3B);
            chk("ws3_rdy", 32'(rdy), 32'(i == 3));
            chk("ws3_we", 32'(we_n), 32'(i != 3));
        end
        step();
        chk("ws3_end", 32'(cs_n), 32'h3F);
        drive(32'hDC10, 1'b1); step();
        chk("above_lim", 32'(cs_n), 32'h3E);
        step();

        // Overlapping windows, inclusive bounds, back-to-back accesses
        cfg(1, 32'hD000, 32'hDFFF, 0, 1'b1);
        cfg(3, 32'hD400, 32'hD7FF, 1, 1'b1);
        drive(32'hD400, 1'b1); step();
        chk("ovl_base3", 32'(cs_n), 32'h37);
        step();
        drive(32'hD3FF, 1'b1); step();
        chk("ovl_b2b1", 32'(cs_n), 32'h3D);
        drive(32'hD7FF, 1'b0); step();
        chk("ovl_lim3", 32'(cs_n), 32'h37);
        finish_access();
        drive(32'hD000, 1'b1); step();
        chk("ovl_base1", 32'(cs_n), 32'h3D);
        drive(32'hDFFF, 1'b1); step();
        chk("ovl_lim1", 32'(cs_n), 32'h3D);
        drive(32'hDC0F, 1'b1); step();
        chk("ovl_prio2", 32'(cs_n), 32'h3B);
        finish_access();

        // Undecoded addresses with entry 0 disabled
        cfg(0, 0, 32'h7FFFF, 0, 1'b0);
        drive(32'h40000, 1'b1); step();
        chk("miss_flag", 32'(miss), 32'd1);
        chk("miss_cs", 32'(cs_n), 32'h3F);
        drive(32'h40001, 1'b1); step();
        chk("miss_b2b", 32'(miss), 32'd1);
        drive(32'hD005, 1'b1); step();
        chk("miss_then_hit", 32'(cs_n), 32'h3D);
        chk("miss_clear", 32'(miss), 32'd0);
        step();
        cfg(0, 0, 32'h7FFFF, 0, 1'b1);

        // Config write in the same cycle as valid uses the old table
        drive(32'h01234, 1'b1);
        cfg(5, 32'h01000, 32'h01FFF, 0, 1'b1);
        chk("pre_write", 32'(cs_n), 32'h3E);
        step();
        drive(32'h01234, 1'b1); step();
        chk("post_write", 32'(cs_n), 32'h1F);
        step();
        cfg(6, 32'h50000, 32'h5FFFF, 0, 1'b1);
        drive(32'h50000, 1'b1); step();
        chk("idx_oob", 32'(cs_n), 32'h3E);
        step();

        // ws=7 with a stray valid and a config rewrite during WAIT
        cfg(4, 32'h20000, 32'h20FFF, 7, 1'b1);
        drive(32'h20010, 1'b1); step();
        step();
        drive(32'h01234, 1'b0); step();
        chk("ovr_set", 32'(overrun), 32'd1);
        cfg(4, 32'h20000, 32'h20FFF, 0, 1'b0);
        chk("ovr_keep_cs", 32'(cs_n), 32'h2F);
        finish_access();
        chk("ovr_idle", 32'(cs_n), 32'h3F);

        // Reset asserted in the 4th WAIT cycle
        cfg(4, 32'h20000, 32'h20FFF, 7, 1'b1);
        drive(32'h20010, 1'b1); step();
        step(); step(); step();
        chk("pre_rst_rdy", 32'(rdy), 32'd0);
        reset = 1'b1;
        m_reset();
        #1;
        chk("arst_cs", 32'(cs_n), 32'h3F);
        chk("arst_rdy", 32'(rdy), 32'd1);
        chk("arst_ovr", 32'(overrun), 32'd0);
        step();
        reset = 1'b0;

        // First valid after reset release is honoured
        drive(32'h01234, 1'b1); step();
        chk("post_rst", 32'(cs_n), 32'h3E);
        step();

        // Randomized traffic and table updates
        for (int i = 0; i < 400; i++) begin
            int k;
            int b;
            k = $urandom_range(0, NWIN - 1);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0:       addr = ADDR_W'($urandom);
                    1:       addr = m_base[k] + ADDR_W'($urandom_range(0, 3));
                    2:       addr = m_limit[k];
                    default: addr = m_base[k] - ADDR_W'(1);
                endcase
                rw    = 1'($urandom);
                valid = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                b         = $urandom_range(0, 32'h7FFFF);
                cfg_we    = 1'b1;
                cfg_idx   = IDX_W'($urandom_range(0, 7));
                cfg_base  = ADDR_W'(b);
                cfg_limit = ADDR_W'(b + $urandom_range(0, 32'h3FFF));
                cfg_ws    = WS_W'($urandom_range(0, 7));
                cfg_en    = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adec_ws.md
ADEC_WS -- requirements
Module: adec_ws

Interface
Parameters:
REQ-001 ADDR_W, default 19, address bus width.
REQ-002 NWIN, default 6, number of decode windows and chip selects.
REQ-003 WS_W, default 3, width of each window's wait-state count.
Ports:
REQ-004 clock  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 addr  in  ADDR_W  CPU address, sampled only when valid=1.
REQ-007 rw  in  1  CPU read(1)/write(0), sampled with addr.
REQ-008 valid  in  1  one-cycle pulse marking the start of a bus cycle.
REQ-009 cfg_we  in  1  window-table write strobe.
REQ-010 cfg_idx  in  $clog2(NWIN)  window index to write.
REQ-011 cfg_base, cfg_limit  in  ADDR_W each  inclusive window bounds.
REQ-012 cfg_ws  in  WS_W  wait states for the window.
REQ-013 cfg_en  in  1  window enable.
REQ-014 cs_n  out  NWIN  active-low chip selects, at most one low.
REQ-015 we_n  out  1  active-low write strobe.
REQ-016 rdy  out  1  CPU RDY; 0 stalls the CPU.
REQ-017 miss  out  1  high for the access cycle of an undecoded address.
REQ-018 overrun  out  1  sticky flag: valid arrived while stalled.

Function
REQ-019 Table: NWIN entries {base, limit, ws, en}; a cfg_we edge writes entry cfg_idx; writes with cfg_idx>=NWIN are ignored.
REQ-020 Match: entry k matches when en=1 and base<=addr<=limit (unsigned, inclusive); base>limit never matches.
REQ-021 Priority: the highest-index matching entry wins, so entry 0 is the background (RAM) window.
REQ-022 FSM states: IDLE, WAIT, ACCESS.
REQ-023 IDLE + valid: latch winner index, rw and ws; go to WAIT with cnt=ws if ws>0, else go to ACCESS.
REQ-024 WAIT: cnt decrements each cycle; at cnt==1, go to ACCESS; rdy=0 throughout WAIT.
REQ-025 ACCESS lasts one cycle with rdy=1; then IDLE, or a new access is accepted as from IDLE if valid=1 (back-to-back).
REQ-026 cs_n[winner]=0 during WAIT and ACCESS, all 1 otherwise; total select length = ws+1 cycles, starting the cycle after valid.
REQ-027 we_n=0 only in ACCESS when latched rw=0.
REQ-028 No match: no cs_n low, ws treated as 0, miss=1 for the ACCESS cycle, rdy stays 1.
REQ-029 valid during WAIT: ignored (latched access unaffected); overrun set to 1, cleared only by reset.
REQ-030 A config write during WAIT/ACCESS does not alter the latched access; it applies from the next accepted valid.
REQ-031 Simultaneous cfg_we and valid: decode uses the pre-write table.
REQ-032 Outputs are registered: no combinational path from addr/valid to cs_n, rdy, we_n or miss.

Reset
REQ-033 reset asserted (any time, including mid-WAIT): FSM=IDLE, cnt=0, cs_n=all 1, we_n=1, rdy=1, miss=0, overrun=0, effective immediately (asynchronous).
REQ-034 Table reset values: entry 0 = {0, all-ones, ws 0, en 1}; entries 1..NWIN-1 = {0, 0, 0, en 0}.
REQ-035 The first valid is honoured on the first rising edge after reset deasserts.

Verification
REQ-036 After reset, valid with addr=0x01234 and rw=1 -> cs_n[0]=0 for exactly 1 cycle, rdy=1, we_n=1.
REQ-037 Entry 2 = {0xDC00, 0xDC0F, ws 3, en 1}, valid with addr=0xDC05 and rw=0 -> cs_n[2] low for 4 cycles, rdy=0 for 3 cycles, we_n=0 in the 4th cycle only; addr=0xDC10 -> cs_n[0].
REQ-038 Overlap: entry 1 = {0xD000,0xDFFF,ws 0} and entry 3 = {0xD400,0xD7FF,ws 1}, addr=0xD400 -> cs_n[3]; addr=0xD3FF -> cs_n[1]; addr equal to base and to limit both match.
REQ-039 Entry 0 disabled, valid with addr=0x40000 -> miss=1 for 1 cycle, cs_n all 1, rdy=1; back-to-back valids in consecutive accesses decode correctly.
REQ-040 ws=7 access, valid pulsed in 2nd WAIT cycle -> overrun=1, original access completes unchanged; reset asserted in 4th WAIT cycle -> cs_n all 1 and rdy=1 immediately; overrun cleared.
